fpa_mul_sequencer: RTL and testbench

Batch initiator for the single-precision floating-point multiplier. It buffers up to DEPTH operand pairs and issues each pair to the multiplier over its i_start/o_done handshake, one at a time. It stores every result together with its exception/overflow/underflow flags in a readable result buffer. It sits between the host/loader side and the multiplier, replacing ad-hoc operand driving with a cycle-exact request/response engine.

---
 rtl/fpa_mul_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fpa_mul_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_mul_sequencer.sv
// rtl/fpa_mul_sequencer.sv - batch initiator for the single-precision floating-point multiplier
//
// Buffers up to DEPTH operand pairs, issues them one at a time to the multiplier
// over its start/done handshake, and stores each result and its flags in a
// readable result buffer.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_wr_en, i_wr_a, i_wr_b           append one operand pair (IDLE only, not when full)
//   i_go                              start a batch over all loaded pairs
//   i_rd_addr, o_rd_result, o_rd_flags  result buffer read, 1-cycle registered latency
//   o_full, o_count                   operand buffer status
//   o_busy, o_batch_done, o_timeout   batch status (timeout is sticky per batch)
//   o_mul_start, o_mul_a, o_mul_b     request to the multiplier
//   i_mul_result, i_mul_exception, i_mul_overflow, i_mul_underflow, i_mul_done
//                                     response from the multiplier
module fpa_mul_sequencer #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [31:0]   i_wr_a,
    input  logic [31:0]   i_wr_b,
    input  logic          i_go,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_result,
    output logic [2:0]    o_rd_flags,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_busy,
    output logic          o_batch_done,
    output logic          o_timeout,
    output logic          o_mul_start,
    output logic [31:0]   o_mul_a,
    output logic [31:0]   o_mul_b,
    input  logic [31:0]   i_mul_result,
    input  logic          i_mul_exception,
    input  logic          i_mul_overflow,
    input  logic          i_mul_underflow,
    input  logic          i_mul_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;

    logic [1:0]    state;
    logic [AW:0]   wr_ptr;
    logic [AW-1:0] idx;
    logic [TW-1:0] tcnt;

    logic [31:0] op_a      [DEPTH];
    logic [31:0] op_b      [DEPTH];
    logic [31:0] res_data  [DEPTH];
    logic [2:0]  res_flags [DEPTH];

    logic        wr_accept;
    logic [AW:0] count_next;
    logic        is_last;
    logic        timed_out;
    logic        capture;

    assign o_full     = (wr_ptr == CNT_FULL);
    assign o_count    = wr_ptr;
    assign wr_accept  = (state == S_IDLE) && i_wr_en && !o_full;
    // A write in the same cycle as i_go belongs to the batch being started.
    assign count_next = wr_accept ? (wr_ptr + CNT_ONE) : wr_ptr;
    assign is_last    = ({1'b0, idx} == (wr_ptr - CNT_ONE));
    // The TIMEOUT-th consecutive WAIT cycle without done abandons the operation.
    assign timed_out  = (state == S_WAIT) && !i_mul_done && (tcnt == T_LAST);
    assign capture    = (state == S_WAIT) && (i_mul_done || timed_out);

    assign o_busy       = (state == S_ISSUE) || (state == S_WAIT);
    assign o_mul_start  = (state == S_ISSUE);
    assign o_batch_done = (state == S_DONE);
    // Operand storage is frozen outside IDLE and idx only moves at capture,
    // so the request stays stable for the whole operation.
    assign o_mul_a      = o_busy ? op_a[idx] : 32'h0;
    assign o_mul_b      = o_busy ? op_b[idx] : 32'h0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            idx       <= '0;
            tcnt      <= '0;
            o_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_accept) begin
                        wr_ptr <= wr_ptr + CNT_ONE;
                    end
                    if (i_go) begin
                        if (count_next != '0) begin
                            idx       <= '0;
                            o_timeout <= 1'b0;
                            state     <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        tcnt <= '0;
                        if (timed_out) begin
                            o_timeout <= 1'b1;
                        end
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_ISSUE;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    wr_ptr <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer storage carries no reset; contents are undefined until written.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            op_a[wr_ptr[AW-1:0]] <= i_wr_a;
            op_b[wr_ptr[AW-1:0]] <= i_wr_b;
        end
        if (capture) begin
            res_data[idx]  <= timed_out ? QNAN : i_mul_result;
            res_flags[idx] <= timed_out ? 3'b100
                                        : {i_mul_exception, i_mul_overflow, i_mul_underflow};
        end
    end

    // Registered read; a same-cycle write to the addressed entry shows the old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_result <= 32'h0;
            o_rd_flags  <= 3'b000;
        end else begin
            o_rd_result <= res_data[i_rd_addr];
            o_rd_flags  <= res_flags[i_rd_addr];
        end
    end

endmodule

// File: tb/tb_fpa_mul_sequencer.sv
// tb/tb_fpa_mul_sequencer.sv - randomized self-checking bench for fpa_mul_sequencer
module tb_fpa_mul_sequencer;

    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 255;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_wr_en;
    logic [31:0]   i_wr_a;
    logic [31:0]   i_wr_b;
    logic          i_go;
    logic [AW-1:0] i_rd_addr;
    logic [31:0]   o_rd_result;
    logic [2:0]    o_rd_flags;
    logic          o_full;
    logic [AW:0]   o_count;
    logic          o_busy;
    logic          o_batch_done;
    logic          o_timeout;
    logic          o_mul_start;
    logic [31:0]   o_mul_a;
    logic [31:0]   o_mul_b;
    logic [31:0]   i_mul_result;
    logic          i_mul_exception;
    logic          i_mul_overflow;
    logic          i_mul_underflow;
    logic          i_mul_done;

    fpa_mul_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_en(i_wr_en), .i_wr_a(i_wr_a), .i_wr_b(i_wr_b),
        .i_go(i_go), .i_rd_addr(i_rd_addr),
        .o_rd_result(o_rd_result), .o_rd_flags(o_rd_flags),
        .o_full(o_full), .o_count(o_count), .o_busy(o_busy),
        .o_batch_done(o_batch_done), .o_timeout(o_timeout),
        .o_mul_start(o_mul_start), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .i_mul_result(i_mul_result), .i_mul_exception(i_mul_exception),
        .i_mul_overflow(i_mul_overflow), .i_mul_underflow(i_mul_underflow),
        .i_mul_done(i_mul_done)
    );

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int base = 0;
    int skip_op = -1;
    bit late_done = 0;
    int fixed_lat = 0;
    bit abort_flag = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating single-precision multiply; returns {exc, ovf, unf, result}.
    function automatic logic [34:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        logic s;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'h7FC00000};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'b0};
        if (e <= 0) return {3'b001, s, 31'b0};
        return {3'b000, s, e[7:0], m};
    endfunction

    // Multiplier model: answers each start after a latency, or not at all for skip_op.
    initial begin : mul_model
        int op, lat;
        logic [31:0] ma, mb;
        logic [34:0] r;
        i_mul_done = 0;
        i_mul_result = 0;
        i_mul_exception = 0;
        i_mul_overflow = 0;
        i_mul_underflow = 0;
        forever begin
            if (o_mul_start === 1'b1) begin
                op = starts - base;
                starts++;
                ma = o_mul_a;
                mb = o_mul_b;
                if (op == skip_op) begin
                    if (late_done) begin
                        repeat (TIMEOUT + 5) @(negedge i_clk);
                        i_mul_result = 32'h12345678;
                        {i_mul_exception, i_mul_overflow, i_mul_underflow} = 3'b011;
                        i_mul_done = 1;
                        @(negedge i_clk);
                        i_mul_done = 0;
                    end else begin
                        @(negedge i_clk);
                    end
                end else begin
                    lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 5));
                    repeat (lat - 1) @(negedge i_clk);
                    if (!abort_flag) begin
                        check("mul_a_stable", o_mul_a, ma);
                        check("mul_b_stable", o_mul_b, mb);
                    end
                    r = fpmul(ma, mb);
                    i_mul_result = r[31:0];
                    {i_mul_exception, i_mul_overflow, i_mul_underflow} = r[34:32];
                    i_mul_done = 1;
                    @(negedge i_clk);
                    i_mul_done = 0;
                end
            end else begin
                @(negedge i_clk);
            end
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        i_wr_en = 1;
        i_wr_a = a;
        i_wr_b = b;
        @(negedge i_clk);
        i_wr_en = 0;
        if (qa.size() < DEPTH) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    task automatic go(input bit wr, input logic [31:0] a, input logic [31:0] b, output int cyc);
        check("count_loaded", 32'(o_count), 32'(qa.size()));
        base = starts;
        i_go = 1;
        if (wr) begin
            i_wr_en = 1;
            i_wr_a = a;
            i_wr_b = b;
        end
        @(negedge i_clk);
        i_go = 0;
        i_wr_en = 0;
        if (wr && qa.size() < DEPTH) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        cyc = 1;
        while (o_batch_done !== 1'b1 && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
        end
        check("batch_done_seen", 32'(o_batch_done), 32'd1);
        check("busy_at_done", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check("done_pulse_width", 32'(o_batch_done), 32'd0);
        check("count_cleared", 32'(o_count), 32'd0);
    endtask

    task automatic read_res(input int i, output logic [31:0] r, output logic [2:0] f);
        i_rd_addr = 5'(i);
        @(negedge i_clk);
        r = o_rd_result;
        f = o_rd_flags;
    endtask

    task automatic verify(input int timed_op);
        logic [31:0] r;
        logic [2:0] f;
        logic [34:0] e;
        check("start_count", 32'(starts - base), 32'(qa.size()));
        check("timeout_flag", 32'(o_timeout), 32'(timed_op >= 0));
        for (int i = 0; i < qa.size(); i++) begin
            e = (i == timed_op) ? {3'b100, 32'h7FC00000} : fpmul(qa[i], qb[i]);
            read_res(i, r, f);
            check($sformatf("result[%0d]", i), r, e[31:0]);
            check($sformatf("flags[%0d]", i), 32'(f), 32'(e[34:32]));
        end
        qa.delete();
        qb.delete();
    endtask

    initial begin : main
        int cyc, n, k;
        logic [31:0] r;
        logic [2:0] f;
        i_rst_n = 0;
        i_wr_en = 0;
        i_wr_a = 0;
        i_wr_b = 0;
        i_go = 0;
        i_rd_addr = 0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;
        @(negedge i_clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_batch_done", 32'(o_batch_done), 32'd0);
        check("rst_mul_start", 32'(o_mul_start), 32'd0);
        check("rst_mul_a", o_mul_a, 32'd0);
        check("rst_mul_b", o_mul_b, 32'd0);
        check("rst_rd_result", o_rd_result, 32'd0);
        check("rst_rd_flags", 32'(o_rd_flags), 32'd0);

        // Known products at fixed latency; the overflow pair rides in with i_go.
        fixed_lat = 4;
        load(32'h3F800000, 32'h40000000);
        load(32'h40400000, 32'h40800000);
        load(32'hC0000000, 32'h3F000000);
        go(1, 32'h7F000000, 32'h7F000000, cyc);
        check("plan_r0", fpmul(qa[0], qb[0]), {3'b000, 32'h40000000});
        check("plan_r1", fpmul(qa[1], qb[1]), {3'b000, 32'h41400000});
        check("plan_r2", fpmul(qa[2], qb[2]), {3'b000, 32'hBF800000});
        verify(-1);
        fixed_lat = 0;

        // Fill past capacity.
        for (int i = 0; i < DEPTH + 2; i++) begin
            load($urandom, $urandom);
            if (i == DEPTH - 2) check("not_full_yet", 32'(o_full), 32'd0);
            if (i == DEPTH - 1) check("full_at_depth", 32'(o_full), 32'd1);
        end
        check("count_at_depth", 32'(o_count), 32'(DEPTH));
        go(0, 0, 0, cyc);
        verify(-1);

        // Random batches.
        for (int b = 0; b < 3; b++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) load($urandom, $urandom);
            go(0, 0, 0, cyc);
            verify(-1);
        end

        // Second of two operations never answers; its done arrives long after.
        skip_op = 1;
        late_done = 1;
        load($urandom, $urandom);
        load($urandom, $urandom);
        go(0, 0, 0, cyc);
        check("timeout_latency", 32'(cyc >= TIMEOUT && cyc <= TIMEOUT + 15), 32'd1);
        verify(1);
        repeat (TIMEOUT + 10) @(negedge i_clk);
        read_res(1, r, f);
        check("late_done_dropped_r", r, 32'h7FC00000);
        check("late_done_dropped_f", 32'(f), 32'd4);
        skip_op = -1;
        late_done = 0;

        // Empty batch.
        go(0, 0, 0, cyc);
        check("empty_latency", 32'(cyc <= 2), 32'd1);
        check("empty_no_start", 32'(starts - base), 32'd0);

        // Timeout flag clears on the next real batch.
        load($urandom, $urandom);
        go(0, 0, 0, cyc);
        verify(-1);

        // Reset during WAIT of the second operation.
        fixed_lat = 4;
        load($urandom, $urandom);
        load($urandom, $urandom);
        load($urandom, $urandom);
        base = starts;
        i_go = 1;
        @(negedge i_clk);
        i_go = 0;
        k = 0;
        while (starts - base < 2 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check("second_op_started", 32'(starts - base), 32'd2);
        @(negedge i_clk);
        abort_flag = 1;
        #2 i_rst_n = 0;
        #1;
        check("abort_mul_start", 32'(o_mul_start), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_count", 32'(o_count), 32'd0);
        check("abort_mul_a", o_mul_a, 32'd0);
        check("abort_rd_result", o_rd_result, 32'd0);
        check("abort_timeout", 32'(o_timeout), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1;
        repeat (10) @(negedge i_clk);
        abort_flag = 0;
        fixed_lat = 0;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 3; i++) load($urandom, $urandom);
        go(0, 0, 0, cyc);
        verify(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
